// File: rtl/enytank_spawner_if.sv
// enytank_spawner_if -- signal bundle between the game controller and the
// enemy-tank spawner.
//   master : drives tick, start, tank_state; observes spawner outputs
//   slave  : the spawner itself
// Signals:
//   tick        game-rate strobe (one clk wide)
//   start       one-clk pulse that launches a wave
//   tank_state  bit i high while slot i's tank is alive
//   tank_en     one-clk spawn request, at most one bit set
//   spawned_cnt tanks issued in the current wave
//   killed_cnt  tanks destroyed in the current wave
//   busy        wave in progress
//   wave_done   wave finished, waiting for the next start
interface enytank_spawner_if #(
    parameter int TANK_NUM = 4,
    parameter int CNT_W    = 8
);
    logic                tick;
    logic                start;
    logic [TANK_NUM-1:0] tank_state;
    logic [TANK_NUM-1:0] tank_en;
    logic [CNT_W-1:0]    spawned_cnt;
    logic [CNT_W-1:0]    killed_cnt;
    logic                busy;
    logic                wave_done;

    modport master (
        output tick, start, tank_state,
        input  tank_en, spawned_cnt, killed_cnt, busy, wave_done
    );

    modport slave (
        input  tick, start, tank_state,
        output tank_en, spawned_cnt, killed_cnt, busy, wave_done
    );
endinterface

// File: rtl/enytank_spawner.sv
// enytank_spawner -- issues enemy tanks into free slots, one at a time,
// spaced by at least SPAWN_GAP ticks, until WAVE_SIZE tanks have been
// issued; the wave ends once WAVE_SIZE kills have been seen.
// Ports:
//   clk     system clock
//   rst     synchronous active-high reset
//   freeze  (only with ENYTANK_SPAWN_FREEZE_EN) ignore ticks while high;
//           kill counting carries on
//   bus     enytank_spawner_if.slave (tick/start/tank_state in,
//           tank_en/spawned_cnt/killed_cnt/busy/wave_done out)
// Build option: define ENYTANK_SPAWN_FREEZE_EN to add the freeze input.
module enytank_spawner #(
    parameter int TANK_NUM  = 4,
    parameter int SPAWN_GAP = 8,
    parameter int WAVE_SIZE = 20,
    parameter int CNT_W     = 8
) (
    input logic clk,
    input logic rst,
`ifdef ENYTANK_SPAWN_FREEZE_EN
    input logic freeze,
`endif
    enytank_spawner_if.slave bus
);
    localparam int PTR_W = (TANK_NUM > 1) ? $clog2(TANK_NUM) : 1;
    localparam int GAP_W = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(SPAWN_GAP - 1);
    localparam logic [CNT_W-1:0] WAVE_MAX = CNT_W'(WAVE_SIZE);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state, state_next;
    logic [TANK_NUM-1:0] state_q;     // tank_state history, one clk old
    logic [TANK_NUM-1:0] pending;     // spawn issued, tank not yet seen alive
    logic [TANK_NUM-1:0] free, kill, rise, onehot;
    logic [TANK_NUM-1:0] tank_en_r;
    logic [PTR_W-1:0]    rr_ptr, sel, ptr_after;
    logic                found;
    logic [GAP_W-1:0]    gap;
    logic [CNT_W-1:0]    spawned, killed, killed_next;
    logic [CNT_W:0]      kill_sum;
    logic                tick_eff, gap_full, spawn, wave_start;

`ifdef ENYTANK_SPAWN_FREEZE_EN
    assign tick_eff = bus.tick & ~freeze;
`else
    assign tick_eff = bus.tick;
`endif

    // Selection works from the registered history, so a slot freed in the
    // same clk as a tick only becomes eligible on a later tick.
    assign rise     = bus.tank_state & ~state_q;
    assign kill     = state_q & ~bus.tank_state;
    assign free     = ~state_q & ~pending;
    assign gap_full = (gap == GAP_MAX);

    // First free slot at or after rr_ptr, wrapping at TANK_NUM-1.
    always_comb begin
        int idx;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < TANK_NUM; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= TANK_NUM) idx = idx - TANK_NUM;
            if (!found && free[idx]) begin
                found = 1'b1;
                sel   = PTR_W'(idx);
            end
        end
    end

    assign onehot    = TANK_NUM'(1) << sel;
    assign ptr_after = (sel == PTR_W'(TANK_NUM - 1)) ? '0 : sel + PTR_W'(1);

    // Kill popcount added to the running total, saturating at WAVE_SIZE.
    always_comb begin
        kill_sum = {1'b0, killed};
        for (int i = 0; i < TANK_NUM; i++)
            kill_sum = kill_sum + (CNT_W+1)'(kill[i]);
        killed_next = (kill_sum >= (CNT_W+1)'(WAVE_SIZE)) ? WAVE_MAX
                                                           : kill_sum[CNT_W-1:0];
    end

    // Next-state and spawn decision. Spawning stops once the wave is fully
    // killed so no request can land in the first DONE clk.
    always_comb begin
        state_next = state;
        wave_start = 1'b0;
        spawn      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_next = RUN;
                    wave_start = 1'b1;
                end
            end
            RUN: begin
                if (killed == WAVE_MAX)
                    state_next = DONE;
                else if (tick_eff && gap_full && (spawned < WAVE_MAX) && found)
                    spawn = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= '0;
            pending   <= '0;
            tank_en_r <= '0;
            rr_ptr    <= '0;
            gap       <= '0;
            spawned   <= '0;
            killed    <= '0;
        end else begin
            state_q   <= bus.tank_state;
            tank_en_r <= '0;
            pending   <= pending & ~rise;
            if (wave_start) begin
                spawned <= '0;
                killed  <= '0;
                pending <= '0;
                // Preloaded full so the first tick of a wave spawns at once.
                gap     <= GAP_MAX;
            end else if (state == RUN) begin
                killed <= killed_next;
                if (spawn) begin
                    tank_en_r <= onehot;
                    pending   <= (pending & ~rise) | onehot;
                    spawned   <= spawned + CNT_W'(1);
                    gap       <= '0;
                    rr_ptr    <= ptr_after;
                end else if (tick_eff && !gap_full) begin
                    gap <= gap + GAP_W'(1);
                end
            end
        end
    end

    assign bus.tank_en     = tank_en_r;
    assign bus.spawned_cnt = spawned;
    assign bus.killed_cnt  = killed;
    assign bus.busy        = (state == RUN);
    assign bus.wave_done   = (state == DONE);
endmodule

// File: tb/tb_enytank_spawner.sv
// tb_enytank_spawner -- directed bench for enytank_spawner with
// TANK_NUM=4, SPAWN_GAP=3, WAVE_SIZE=6. Spawned tanks come alive about two
// clks after their tank_en pulse; kills are applied by clearing alive bits.
// The freeze scenario is compiled only with ENYTANK_SPAWN_FREEZE_EN.
module tb_enytank_spawner;
    localparam int TN = 4;
    localparam int SG = 3;
    localparam int WS = 6;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic freeze = 1'b0;
    always #5 clk = ~clk;

    enytank_spawner_if #(.TANK_NUM(TN), .CNT_W(CW)) bus();

    enytank_spawner #(
        .TANK_NUM(TN), .SPAWN_GAP(SG), .WAVE_SIZE(WS), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef ENYTANK_SPAWN_FREEZE_EN
        .freeze(freeze),
`endif
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    logic [TN-1:0] alive = '0;
    logic [TN-1:0] en_d1 = '0;
    logic [TN-1:0] exp_en [7];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clk; outputs sampled 1 time unit after the edge, then the
    // alive model is advanced and driven back as tank_state.
    task automatic step();
        @(posedge clk);
        #1;
        alive = alive | en_d1;
        en_d1 = bus.tank_en;
        bus.tank_state = alive;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic tick_once();
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
    endtask

    initial begin
        bus.tick = 1'b0;
        bus.start = 1'b0;
        bus.tank_state = '0;
        exp_en = '{4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0100};

        // Reset state
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        check("rst_tank_en", 32'(bus.tank_en), 0);
        check("rst_spawned", 32'(bus.spawned_cnt), 0);
        check("rst_killed", 32'(bus.killed_cnt), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_wave_done", 32'(bus.wave_done), 0);

        // Start a wave, ticks 1..7
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("start_busy", 32'(bus.busy), 1);
        for (int t = 0; t < 7; t++) begin
            tick_once();
            check($sformatf("tick%0d_en", t + 1), 32'(bus.tank_en), 32'(exp_en[t]));
            idle(1);
            check($sformatf("tick%0d_en_one_clk", t + 1), 32'(bus.tank_en), 0);
            idle(1);
        end
        check("a_spawned3", 32'(bus.spawned_cnt), 3);

        // Fill slot 3, then all slots alive: no spawn while saturated
        tick_once(); idle(2);
        tick_once(); idle(2);
        tick_once();
        check("tick10_en", 32'(bus.tank_en), 32'h8);
        idle(2);
        for (int t = 0; t < 3; t++) begin
            tick_once();
            check($sformatf("full_tick%0d_en", t), 32'(bus.tank_en), 0);
            idle(2);
        end
        check("b_spawned4", 32'(bus.spawned_cnt), 4);

        // Kill slot 2; next tick reuses it
        alive[2] = 1'b0;
        bus.tank_state = alive;
        step();
        check("b_killed1", 32'(bus.killed_cnt), 1);
        tick_once();
        check("refill_en", 32'(bus.tank_en), 32'h4);
        check("b_spawned5", 32'(bus.spawned_cnt), 5);
        idle(3);

        // Two simultaneous kills
        alive[0] = 1'b0;
        alive[3] = 1'b0;
        bus.tank_state = alive;
        step();
        check("c_killed3", 32'(bus.killed_cnt), 3);

        // Sixth spawn, then spawned_cnt holds at WAVE_SIZE
        tick_once(); idle(2);
        tick_once(); idle(2);
        tick_once();
        check("d_sixth_en", 32'(bus.tank_en), 32'h8);
        idle(2);
        for (int t = 0; t < 3; t++) begin
            tick_once();
            check($sformatf("d_cap_tick%0d_en", t), 32'(bus.tank_en), 0);
            idle(2);
        end
        check("d_spawned6", 32'(bus.spawned_cnt), 6);

        // Remaining kills finish the wave
        alive[1] = 1'b0;
        alive[2] = 1'b0;
        bus.tank_state = alive;
        step();
        check("d_killed5", 32'(bus.killed_cnt), 5);
        alive[3] = 1'b0;
        bus.tank_state = alive;
        step();
        check("d_killed6", 32'(bus.killed_cnt), 6);
        check("d_not_done_yet", 32'(bus.wave_done), 0);
        step();
        check("d_wave_done", 32'(bus.wave_done), 1);
        check("d_busy_off", 32'(bus.busy), 0);
        tick_once();
        check("d_done_no_en", 32'(bus.tank_en), 0);

        // Restart from DONE
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("restart_busy", 32'(bus.busy), 1);
        check("restart_spawned", 32'(bus.spawned_cnt), 0);
        check("restart_killed", 32'(bus.killed_cnt), 0);
        check("restart_done_off", 32'(bus.wave_done), 0);

        // Reset on a spawning tick
        bus.tick = 1'b1;
        rst = 1'b1;
        step();
        bus.tick = 1'b0;
        rst = 1'b0;
        check("e_tank_en", 32'(bus.tank_en), 0);
        check("e_busy", 32'(bus.busy), 0);
        check("e_wave_done", 32'(bus.wave_done), 0);
        check("e_spawned", 32'(bus.spawned_cnt), 0);
        check("e_killed", 32'(bus.killed_cnt), 0);
        step();
        check("e_tank_en_after", 32'(bus.tank_en), 0);

`ifdef ENYTANK_SPAWN_FREEZE_EN
        // Freeze: ticks ignored, gap counter holds
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        tick_once();
        check("f_first_en", 32'(bus.tank_en), 32'h1);
        idle(2);
        freeze = 1'b1;
        for (int t = 0; t < 5; t++) begin
            tick_once();
            check($sformatf("f_frozen%0d_en", t), 32'(bus.tank_en), 0);
            idle(1);
        end
        freeze = 1'b0;
        tick_once();
        check("f_gap1_en", 32'(bus.tank_en), 0);
        idle(1);
        tick_once();
        check("f_gap2_en", 32'(bus.tank_en), 0);
        idle(1);
        tick_once();
        check("f_resume_en", 32'(bus.tank_en), 32'h2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/enytank_spawner.md
ENYTANK_SPAWNER -- requirements
Module: enytank_spawner

Interface
REQ-001 The block SHALL expose parameter TANK_NUM, default 4, the number of enemy tank slots (1..16).
REQ-002 The block SHALL expose parameter SPAWN_GAP, default 8, the minimum number of ticks between spawns (>=1).
REQ-003 The block SHALL expose parameter WAVE_SIZE, default 20, the total number of tanks per wave (>=1).
REQ-004 The block SHALL expose parameter CNT_W, default 8, the counter width (2^CNT_W > WAVE_SIZE).
REQ-005 The block SHALL have one clock and a synchronous, active-high reset: `clk  in  1`, the system clock, and `rst  in  1`, the synchronous active-high reset.
REQ-006 The block SHALL have `tick  in  1`: a one-clk game-rate strobe (4 Hz domain event); all timing counts ticks.
REQ-007 The block SHALL have `start  in  1`: a one-clk pulse that starts a wave.
REQ-008 The block SHALL have `tank_state  in  TANK_NUM`: bit i is 1 while slot i's tank is alive.
REQ-009 The block SHALL have `tank_en  out  TANK_NUM`: bit i is a one-clk spawn request for slot i.
REQ-010 The block SHALL have `spawned_cnt  out  CNT_W` (tanks issued this wave) and `killed_cnt  out  CNT_W` (tanks destroyed this wave).
REQ-011 The block SHALL have `busy  out  1` (FSM in RUN) and `wave_done  out  1` (FSM in DONE).

Function
REQ-012 The FSM SHALL have the states IDLE, RUN and DONE; start in IDLE or DONE SHALL go to RUN, clear both counters, pending bits and the gap counter, and preload the gap counter to SPAWN_GAP-1; start in RUN SHALL be ignored.
REQ-013 In RUN, each tick SHALL increment the gap counter, which saturates at SPAWN_GAP-1.
REQ-014 A slot SHALL be free when its tank_state bit is 0 and its pending bit is 0.
REQ-015 A spawn SHALL occur on a tick when the gap counter already equals SPAWN_GAP-1, spawned_cnt < WAVE_SIZE, and at least one slot is free.
REQ-016 On a spawn, the block SHALL pick the first free slot searching round-robin from rr_ptr upward with wrap at TANK_NUM-1 -> 0, assert that tank_en bit for exactly one clk starting the clk after the tick, and in the same edge set the slot's pending bit, increment spawned_cnt, clear the gap counter, and set rr_ptr to the chosen slot + 1 (wrapping).
REQ-017 If no slot is free at the spawn point, the block SHALL issue no spawn and hold the gap counter saturated, spawning on the first later tick with a free slot.
REQ-018 A slot's pending bit SHALL clear on the clk where its tank_state bit is observed rising; while pending, the slot is never reselected.
REQ-019 The block SHALL register tank_state each clk; a 1->0 transition on bit i SHALL be a kill, and killed_cnt SHALL add the number of kills in that clk (popcount, multiple simultaneous kills counted).
REQ-020 Kills SHALL count only in RUN; killed_cnt SHALL saturate at WAVE_SIZE.
REQ-021 When killed_cnt reaches WAVE_SIZE, the FSM SHALL go RUN -> DONE on the next edge, and no tank_en SHALL be asserted in DONE or IDLE.
REQ-022 When a tick and a kill fall in the same clk, both SHALL be processed; the freed slot SHALL be selectable only from the following tick (registered state is used).
REQ-023 tank_en SHALL be registered, with at most one bit high per clk.

Reset
REQ-024 When rst=1 at a clk edge, the block SHALL enter IDLE and set tank_en=0, spawned_cnt=0, killed_cnt=0, busy=0, wave_done=0, rr_ptr=0, clear all pending bits, and reset the tank_state history to 0.
REQ-025 Reset asserted mid-wave SHALL abort the wave immediately, with no tank_en pulse on the following clk.

Configuration
REQ-026 The block SHALL support macro ENYTANK_SPAWN_FREEZE_EN; when it is defined, it SHALL add input port `freeze  in  1`, and while freeze=1 in RUN, ticks SHALL be ignored (no gap advance, no spawn) while kill counting continues.
REQ-027 When ENYTANK_SPAWN_FREEZE_EN is undefined, the freeze port SHALL be absent and the behaviour SHALL be identical to freeze tied 0.

Verification (TANK_NUM=4, SPAWN_GAP=3, WAVE_SIZE=6, tank_state echoes tank_en 2 clk later)
REQ-028 The bench SHALL cover: start, then ticks 1..7 -> tank_en pulses 0001 after tick1, 0010 after tick4, 0100 after tick7; spawned_cnt=3.
REQ-029 The bench SHALL cover: all 4 slots alive, spawned_cnt=4, gap saturated -> no spawn on ticks; kill slot 2 -> next tick spawns slot 2 (0100).
REQ-030 The bench SHALL cover: slots 0 and 3 die in the same clk -> killed_cnt increases by 2 in one clk.
REQ-031 The bench SHALL cover: 6 spawns then 6 kills -> spawned_cnt stops at 6, wave_done=1 one clk after the 6th kill, and start re-enters RUN with the counters at 0.
REQ-032 The bench SHALL cover: rst pulsed in the same clk as a spawning tick -> tank_en stays 0000, state IDLE, and counters 0.
REQ-033 The bench SHALL cover, with ENYTANK_SPAWN_FREEZE_EN defined: freeze=1 during 5 ticks -> no tank_en, gap counter unchanged; after freeze=0, the next spawn follows the normal gap.
